// File: rtl/div_result_fifo.sv
// div_result_fifo
//   Result buffer between the restoring divider and its consumer. Each
//   quotient/remainder pair offered on the divider's dest_valid/dest_ready
//   handshake is written into a DEPTH-entry FIFO. The consumer drains the FIFO
//   through its own valid/ready pair, so consumer back-pressure never holds the
//   divider in its result-hold state while free entries remain.
//
//   Optional feature macro: DIV_SIGN_FIX_EN
//     When defined, a push stores the modulo-2^WIDTH negation of the quotient
//     (in_neg_q=1) and/or of the remainder (in_neg_r=1). When undefined, the
//     in_neg_* inputs are ignored and values are stored unmodified.
//
//   Ports
//     clk           system clock, all state on the rising edge
//     rst           asynchronous active-low reset
//     in_valid      divider result valid (divider dest_valid)
//     in_ready      FIFO can accept (divider dest_ready), = !full
//     in_quotient   unsigned quotient from divider
//     in_remainder  unsigned remainder from divider
//     in_neg_q      negate quotient on store (sign-fix build only)
//     in_neg_r      negate remainder on store (sign-fix build only)
//     out_valid     head entry available, = !empty
//     out_ready     consumer accepts head entry
//     out_quotient  head quotient
//     out_remainder head remainder
//     count         occupancy 0..DEPTH
//     full          count == DEPTH
//     empty         count == 0
//     done_cnt      results popped, saturating at 16'hFFFF
module div_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_quotient,
  input  logic [WIDTH-1:0]         in_remainder,
  input  logic                     in_neg_q,
  input  logic                     in_neg_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_quotient,
  output logic [WIDTH-1:0]         out_remainder,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              done_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [WIDTH-1:0] neg_mod(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  logic [WIDTH-1:0] mem_quo_q [DEPTH];
  logic [WIDTH-1:0] mem_quo_d [DEPTH];
  logic [WIDTH-1:0] mem_rem_q [DEPTH];
  logic [WIDTH-1:0] mem_rem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      done_cnt_q, done_cnt_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wr_quo;
  logic [WIDTH-1:0] wr_rem;

  // Handshake flags depend on registered occupancy only; a full FIFO refuses
  // a push even when the consumer pops in the same cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef DIV_SIGN_FIX_EN
  assign wr_quo = in_neg_q ? neg_mod(in_quotient)  : in_quotient;
  assign wr_rem = in_neg_r ? neg_mod(in_remainder) : in_remainder;
`else
  logic unused_neg;
  assign unused_neg = in_neg_q ^ in_neg_r;
  assign wr_quo     = in_quotient;
  assign wr_rem     = in_remainder;
`endif

  always_comb begin
    mem_quo_d  = mem_quo_q;
    mem_rem_d  = mem_rem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    done_cnt_d = done_cnt_q;
    if (push) begin
      mem_quo_d[wr_ptr_q] = wr_quo;
      mem_rem_d[wr_ptr_q] = wr_rem;
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      done_cnt_d = sat_inc16(done_cnt_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_quo_q[i] <= '0;
        mem_rem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_cnt_q <= '0;
    end else begin
      mem_quo_q  <= mem_quo_d;
      mem_rem_q  <= mem_rem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign out_quotient  = mem_quo_q[rd_ptr_q];
  assign out_remainder = mem_rem_q[rd_ptr_q];
  assign count         = count_q;
  assign done_cnt      = done_cnt_q;

endmodule

// File: doc/div_result_fifo.md
Name: div_result_fifo

Overview:
- Sits directly downstream of the restoring-division datapath/controller pair.
- Consumes each quotient/remainder result through the divider's dest_valid/dest_ready handshake and buffers results in a DEPTH-entry FIFO.
- Presents results to the consumer through its own valid/ready handshake, so that downstream back-pressure does not stall the divider in its hold state.
- Keeps occupancy flags and a count of delivered results.

Parameters:
WIDTH, 16, bit width of quotient and remainder
DEPTH, 4, number of FIFO entries; power of two, at least 2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  divider result valid (driven from divider dest_valid)
in_ready  output  1  FIFO can accept (drives divider dest_ready)
in_quotient  input  WIDTH  unsigned quotient from divider
in_remainder  input  WIDTH  unsigned remainder from divider
in_neg_q  input  1  quotient must be negated (sign-fix only)
in_neg_r  input  1  remainder must be negated (sign-fix only)
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_quotient  output  WIDTH  head quotient
out_remainder  output  WIDTH  head remainder
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
done_cnt  output  16  number of results popped, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low. While rst is 0:
  - write pointer, read pointer and count are 0; empty=1, full=0;
  - in_ready=1, out_valid=0, out_quotient=0, out_remainder=0, done_cnt=0;
  - storage entries are cleared to 0.
- Push: occurs on a clock edge where in_valid && in_ready.
  - The entry is written at the write pointer; the pointer wraps modulo DEPTH.
  - in_ready = !full, combinational from registered state only (no dependence on out_ready, so there is no full-state pass-through).
- Pop: occurs on a clock edge where out_valid && out_ready.
  - The read pointer advances and wraps modulo DEPTH.
  - done_cnt increments and holds at 16'hFFFF.
- Outputs:
  - out_valid = !empty.
  - out_quotient and out_remainder are read combinationally from the head entry. When empty they show the last-read location, which is don't-care, but they are 0 after reset.
- Latency: a result pushed at edge N is visible on out_* with out_valid=1 after edge N. There is no empty-state bypass, so minimum latency is 1 cycle.
- Simultaneous push and pop:
  - Not full: both take effect and count is unchanged.
  - Full: only the pop occurs, because in_ready=0.
  - Empty: only the push occurs, because out_valid=0.
- Pointers are $clog2(DEPTH) bits. count is tracked separately and is never derived from pointer difference alone.
- Protocol rules:
  - Once out_valid rises, the head data stays stable until popped.
  - in_valid held while in_ready=0 causes no write. The divider holds its result until accepted.
- Reset mid-operation discards all contents. No result is presented after rst deasserts until a new push.

Optional Feature:
- Macro: DIV_SIGN_FIX_EN.
- When defined, each push stores the two's complement of in_quotient when in_neg_q=1 and of in_remainder when in_neg_r=1. This is a modulo 2^WIDTH negation, computed combinationally before the write with no extra latency.
- When not defined, in_neg_q and in_neg_r are ignored and values are stored unmodified. The ports remain present in both builds.

Test Plan:
- Reset, then a single result: push q=7, r=3 with out_ready=1 -> out_valid=1 one cycle after the push with 7/3; popped next edge; empty=1, done_cnt=1.
- Fill with out_ready=0: push 4 results (q=1,2,3,4) -> count=4, full=1, in_ready=0. A held fifth in_valid is not written; draining yields 1,2,3,4 in order.
- Simultaneous push and pop at count=2 for 10 cycles -> count stays 2; the output sequence matches the input order across pointer wrap.
- Full plus simultaneous: count=4 with in_valid=1 and out_ready=1 -> only the pop occurs, count=3; the next cycle accepts the push.
- Assert rst low mid-stream at count=3 -> count=0, out_valid=0, done_cnt=0 immediately, with no clock edge needed; no stale data afterwards.
- DIV_SIGN_FIX_EN build, WIDTH=16, push q=5 with in_neg_q=1 and r=2 with in_neg_r=0 -> out_quotient=16'hFFFB, out_remainder=2.
- Same stimulus in a non-sign-fix build -> 5 and 2.
